sobol_point_sequencer: RTL
==========================

Name: sobol_point_sequencer

Overview:
- Initiator-side companion to the `sobol` generator.
- Walks a block of Sobol points (`num_points` indices starting at `start_idx`), issuing one (idx, dim) request per dimension 0..M-1 over valid/ready.
- Collects `sobol_out` responses in order and tags each with its idx/dim. Forwards them to the downstream path builder as a framed stream with per-point and per-block last flags.

Parameters:
- WIDTH, 32, Sobol index and sample width.
- M, 50, number of dimensions per point.
- MAX_OUT, 4, maximum in-flight requests; also the tag FIFO depth (power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a block when idle.
- start_idx  in  WIDTH  first Sobol index; sampled on accepted start.
- num_points  in  WIDTH  points in block; sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when block is complete.
- err  out  1  sticky; response arrived with zero outstanding.
- req_valid  out  1  request valid to sobol.
- req_ready  in  1  sobol `ready_out`.
- req_idx  out  WIDTH  request index.
- req_dim  out  $clog2(M)  request dimension.
- rsp_valid  in  1  sobol `valid_out`.
- rsp_ready  out  1  to sobol `ready_in`.
- rsp_data  in  WIDTH  sobol `sobol_out`.
- out_valid  out  1  sample valid downstream.
- out_ready  in  1  downstream ready.
- out_data  out  WIDTH  sample.
- out_idx  out  WIDTH  sample index.
- out_dim  out  $clog2(M)  sample dimension.
- out_last_dim  out  1  out_dim == M-1.
- out_last  out  1  final sample of block.

Behaviour:
- Reset: all outputs 0. FSM → IDLE; counters, tag FIFO and err cleared. Reset mid-block abandons the block. The sobol instance shares the reset, so no stale responses arrive.
- FSM IDLE → ISSUE → DRAIN → FIN → IDLE.
- IDLE:
  - start with num_points>0: latch start_idx/num_points, busy=1, → ISSUE.
  - start with num_points==0: busy=1 for one cycle, → FIN.
- ISSUE:
  - req_valid=1 iff outstanding<MAX_OUT and the tag FIFO is not full.
  - Request order: point-major, dim-minor, i.e. (s,0),(s,1)…(s,M-1),(s+1,0)…
  - req_idx/req_dim change only after a handshake (req_valid&&req_ready). They are held stable while req_valid && !req_ready.
  - After the request (s+N-1, M-1) is accepted: → DRAIN.
  - First req_valid appears the cycle after start is accepted.
- Index arithmetic: req_idx wraps mod 2^WIDTH (e.g. start_idx=FFFF_FFFF → next point 0000_0000).
- Handshake accounting:
  - Each request handshake pushes {idx, dim, last_dim, last} into the tag FIFO and increments outstanding.
  - Each response handshake (rsp_valid&&rsp_ready) pops the FIFO and decrements outstanding.
  - Both in the same cycle leave outstanding unchanged.
- rsp_ready = (outstanding>0) && (!out_valid || out_ready).
  - rsp_valid with outstanding==0 sets err and is not accepted.
- Output register (1-cycle latency):
  - On a response handshake, out_data/out_idx/out_dim/out_last_dim/out_last load from rsp_data and the FIFO head; out_valid=1 next cycle.
  - out_valid clears on out_ready with no new response.
  - All out_* are held stable while out_valid && !out_ready.
- DRAIN: once outstanding==0 and (out_valid==0 or the last beat handshakes) → FIN.
- FIN: done=1 for one cycle, busy=0 next cycle, → IDLE.
- start while busy is ignored.
- Responses are in order; no reordering is supported.

Test Plan:
- start_idx=0, num_points=2, M=50, req_ready=rsp path always ready → exactly 100 request handshakes in order (0,0)…(1,49). out_last_dim on beats 50 and 100, out_last only on beat 100. done pulses once, busy drops the cycle after.
- Downstream stall: out_ready=0 for 10 cycles mid-block → rsp_ready=0, out_* stable throughout. Outstanding peaks at MAX_OUT=4 and req_valid=0 while full. No sample lost or duplicated.
- Random req_ready and out_ready (70% high), num_points=5 → 250 output beats. out_idx/out_dim match issue order and err stays 0.
- num_points=0 → zero requests, done pulse 1 cycle after start, out_valid never asserted.
- start_idx=32'hFFFF_FFFF, num_points=2 → second point's req_idx=0. Downstream out_idx sequence is FFFF_FFFF×50 then 0×50.
- rst asserted with 3 outstanding → all outputs 0 asynchronously, FSM IDLE. A new start afterwards completes normally. Separately, a forced rsp_valid in IDLE → err=1 and holds until rst.

Source files
------------

// File: rtl/sobol_point_sequencer_if.sv
// Request, response and downstream sample channels between the Sobol point
// sequencer (master), the sobol generator and the path builder.
interface sobol_point_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int M     = 50
);
  localparam int DIM_W = (M > 1) ? $clog2(M) : 1;

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_idx;
  logic [DIM_W-1:0] req_dim;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] out_idx;
  logic [DIM_W-1:0] out_dim;
  logic             out_last_dim;
  logic             out_last;

  modport master (
    output req_valid, req_idx, req_dim,
    input  req_ready,
    input  rsp_valid, rsp_data,
    output rsp_ready,
    output out_valid, out_data, out_idx, out_dim, out_last_dim, out_last,
    input  out_ready
  );

  modport slave (
    input  req_valid, req_idx, req_dim,
    output req_ready,
    output rsp_valid, rsp_data,
    input  rsp_ready,
    input  out_valid, out_data, out_idx, out_dim, out_last_dim, out_last,
    output out_ready
  );
endinterface

// File: rtl/sobol_point_sequencer.sv
// Issues (idx, dim) requests for a block of Sobol points, pairs in-order
// responses with their tags and streams them downstream with point/block framing.
module sobol_point_sequencer #(
  parameter int WIDTH   = 32,
  parameter int M       = 50,
  parameter int MAX_OUT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIDTH-1:0]         start_idx,
  input  logic [WIDTH-1:0]         num_points,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  sobol_point_sequencer_if.master  bus
);
  localparam int DIM_W = (M > 1) ? $clog2(M) : 1;
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [DIM_W-1:0] LAST_DIM = DIM_W'(M - 1);
  localparam logic [CNT_W-1:0] OUT_MAX  = CNT_W'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] idx;
    logic [DIM_W-1:0] dim;
    logic             last_dim;
    logic             last;
  } tag_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cur_idx;
  logic [DIM_W-1:0] cur_dim;
  logic [WIDTH-1:0] pts_left;
  logic [CNT_W-1:0] outstanding;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  tag_t             tag_mem [MAX_OUT];
  tag_t             issue_tag, out_tag;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             req_valid, req_fire;
  logic             rsp_ready, rsp_fire;
  logic             is_last_dim;

  assign is_last_dim = (cur_dim == LAST_DIM);
  assign issue_tag   = {cur_idx, cur_dim, is_last_dim, is_last_dim && (pts_left == WIDTH'(1))};
  assign req_fire    = req_valid && bus.req_ready;
  // A response is only taken when it can land in the output register this cycle.
  assign rsp_ready   = (outstanding != '0) && (!out_valid || bus.out_ready);
  assign rsp_fire    = bus.rsp_valid && rsp_ready;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    req_valid = 1'b0;
    unique case (state_q)
      IDLE:  if (start) state_d = (num_points != '0) ? ISSUE : FIN;
      ISSUE: begin
        // Tag FIFO depth equals MAX_OUT, so outstanding < MAX_OUT also means not full.
        req_valid = (outstanding < OUT_MAX);
        if (req_valid && bus.req_ready && issue_tag.last) state_d = DRAIN;
      end
      DRAIN: if ((outstanding == '0) && (!out_valid || bus.out_ready)) state_d = FIN;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx     <= '0;
      cur_dim     <= '0;
      pts_left    <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
    end else begin
      if ((state_q == IDLE) && start) begin
        cur_idx  <= start_idx;
        cur_dim  <= '0;
        pts_left <= num_points;
      end else if (req_fire) begin
        if (is_last_dim) begin
          cur_dim  <= '0;
          cur_idx  <= cur_idx + WIDTH'(1);
          pts_left <= pts_left - WIDTH'(1);
        end else begin
          cur_dim  <= cur_dim + DIM_W'(1);
        end
      end

      if (req_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rsp_fire) rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (bus.rsp_valid && (outstanding == '0)) err <= 1'b1;

      if (rsp_fire) begin
        out_valid <= 1'b1;
        out_data  <= bus.rsp_data;
        out_tag   <= tag_mem[rd_ptr];
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: tag storage is not reset; the cleared pointers and outstanding count
  // are what define which entries are live.
  always_ff @(posedge clk) begin
    if (req_fire) tag_mem[wr_ptr] <= issue_tag;
  end

  assign bus.req_valid    = req_valid;
  assign bus.req_idx      = cur_idx;
  assign bus.req_dim      = cur_dim;
  assign bus.rsp_ready    = rsp_ready;
  assign bus.out_valid    = out_valid;
  assign bus.out_data     = out_data;
  assign bus.out_idx      = out_tag.idx;
  assign bus.out_dim      = out_tag.dim;
  assign bus.out_last_dim = out_tag.last_dim;
  assign bus.out_last     = out_tag.last;
endmodule
